fractcam_update_ctrl: RTL and testbench

Rule-update sequencer for the FRACTCAM LUTRAM match array. It accepts one ternary rule (key, mask, entry index) through a valid/ready handshake. It then writes the rule into every LUTRAM sub-block of that entry by sweeping all 2^SUB sub-key addresses, one per cycle. It sits upstream of the search-path pipeline registers and holds a stall on the search pipeline while a write sweep is in flight.

---
 rtl/fractcam_pkg.sv | 14 +
 rtl/fractcam_subword_enc.sv | 13 +
 rtl/fractcam_update_ctrl.sv | 126 ++++++++++++
 tb/tb_fractcam_update_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/fractcam_pkg.sv
// Shared types and sizing helpers for the FRACTCAM rule-update path.
package fractcam_pkg;

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

  localparam int DEF_SUB   = 5;
  localparam int DEF_WIDTH = 40;

  // Number of LUTRAM sub-blocks needed to cover a key of the given width.
  function automatic int nb_of(input int width, input int sub);
    return (width + sub - 1) / sub;
  endfunction

endpackage

// File: rtl/fractcam_subword_enc.sv
// One sub-block's ternary match bit for a given LUTRAM sub-key address.
module fractcam_subword_enc #(
  parameter int SUB = 5
) (
  input  logic [SUB-1:0] c,
  input  logic [SUB-1:0] key_b,
  input  logic [SUB-1:0] mask_b,
  output logic           wbit
);

  assign wbit = ~|((c ^ key_b) & ~mask_b);

endmodule

// File: rtl/fractcam_update_ctrl.sv
// Rule-update sequencer: sweeps all 2^SUB sub-key addresses of one CAM entry.
// Build option FRACTCAM_INVALIDATE_EN adds upd_inv, which erases the entry instead.
module fractcam_update_ctrl
  import fractcam_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int SUB    = DEF_SUB,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6,
  parameter int NB     = nb_of(WIDTH, SUB)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              upd_valid,
  output logic              upd_ready,
  input  logic [WIDTH-1:0]  upd_key,
  input  logic [WIDTH-1:0]  upd_mask,
  input  logic [ADDR_W-1:0] upd_entry,
`ifdef FRACTCAM_INVALIDATE_EN
  input  logic              upd_inv,
`endif
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_row,
  output logic [SUB-1:0]    wr_lut_addr,
  output logic [NB-1:0]     wr_data,
  output logic              search_stall,
  output logic              upd_done
);

  localparam int PW = NB * SUB;

  if (DEPTH > (1 << ADDR_W)) begin : g_bad_depth
    $error("ADDR_W too narrow for DEPTH");
  end

  state_t             state;
  logic [SUB-1:0]     c;
  logic [WIDTH-1:0]   key_q, mask_q;
  logic               inv_q;
  logic               inv_nxt;
  logic [SUB-1:0]     enc_c;
  logic [PW-1:0]      enc_key, enc_mask;
  logic [NB-1:0]      enc_bits;

  assign upd_ready   = (state == IDLE);
  assign wr_lut_addr = c;

  // Encoders look one step ahead so wr_data can be registered alongside c.
  always_comb begin
    enc_key  = '0;
    enc_mask = '1;
    if (state == IDLE) begin
      enc_c                = '0;
      enc_key[WIDTH-1:0]   = upd_key;
      enc_mask[WIDTH-1:0]  = upd_mask;
    end else begin
      enc_c                = c + SUB'(1);
      enc_key[WIDTH-1:0]   = key_q;
      enc_mask[WIDTH-1:0]  = mask_q;
    end
  end

`ifdef FRACTCAM_INVALIDATE_EN
  assign inv_nxt = (state == IDLE) ? upd_inv : inv_q;
`else
  assign inv_nxt = 1'b0;
`endif

  for (genvar b = 0; b < NB; b++) begin : g_enc
    fractcam_subword_enc #(.SUB(SUB)) u_enc (
      .c      (enc_c),
      .key_b  (enc_key[b*SUB +: SUB]),
      .mask_b (enc_mask[b*SUB +: SUB]),
      .wbit   (enc_bits[b])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      c            <= '0;
      key_q        <= '0;
      mask_q       <= '0;
      inv_q        <= 1'b0;
      wr_en        <= 1'b0;
      wr_row       <= '0;
      wr_data      <= '0;
      search_stall <= 1'b0;
      upd_done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (upd_valid) begin
            state        <= WRITE;
            key_q        <= upd_key;
            mask_q       <= upd_mask;
            inv_q        <= inv_nxt;
            c            <= '0;
            wr_en        <= 1'b1;
            wr_row       <= upd_entry;
            wr_data      <= inv_nxt ? '0 : enc_bits;
            search_stall <= 1'b1;
          end
        end
        WRITE: begin
          if (c == '1) begin
            state    <= DONE;
            wr_en    <= 1'b0;
            wr_data  <= '0;
            upd_done <= 1'b1;
          end else begin
            c       <= c + SUB'(1);
            wr_data <= inv_nxt ? '0 : enc_bits;
          end
        end
        DONE: begin
          state        <= IDLE;
          upd_done     <= 1'b0;
          search_stall <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fractcam_update_ctrl.sv
// Directed + random bench for fractcam_update_ctrl against a bit-level ternary model.
module tb_fractcam_update_ctrl;

  localparam int WIDTH  = 40;
  localparam int SUB    = 5;
  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;
  localparam int NB     = (WIDTH + SUB - 1) / SUB;
  localparam int NLUT   = 1 << SUB;

  logic              clk = 1'b0;
  logic              reset;
  logic              upd_valid;
  logic              upd_ready;
  logic [WIDTH-1:0]  upd_key, upd_mask;
  logic [ADDR_W-1:0] upd_entry;
`ifdef FRACTCAM_INVALIDATE_EN
  logic              upd_inv;
`endif
  logic              wr_en;
  logic [ADDR_W-1:0] wr_row;
  logic [SUB-1:0]    wr_lut_addr;
  logic [NB-1:0]     wr_data;
  logic              search_stall;
  logic              upd_done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fractcam_update_ctrl #(
    .WIDTH(WIDTH), .SUB(SUB), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .NB(NB)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .upd_valid    (upd_valid),
    .upd_ready    (upd_ready),
    .upd_key      (upd_key),
    .upd_mask     (upd_mask),
    .upd_entry    (upd_entry),
`ifdef FRACTCAM_INVALIDATE_EN
    .upd_inv      (upd_inv),
`endif
    .wr_en        (wr_en),
    .wr_row       (wr_row),
    .wr_lut_addr  (wr_lut_addr),
    .wr_data      (wr_data),
    .search_stall (search_stall),
    .upd_done     (upd_done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // A sub-block is written 1 at address c when every non-don't-care key bit
  // inside it equals the corresponding bit of c; bits beyond WIDTH never care.
  function automatic logic [NB-1:0] model(input logic [WIDTH-1:0] k, input logic [WIDTH-1:0] m,
                                          input int c, input bit inv);
    logic [NB-1:0] r;
    for (int b = 0; b < NB; b++) begin
      r[b] = 1'b1;
      for (int i = 0; i < SUB; i++) begin
        int p;
        p = b * SUB + i;
        if (p < WIDTH)
          if (!m[p] && (((c >> i) & 1) != int'(k[p]))) r[b] = 1'b0;
      end
    end
    return inv ? '0 : r;
  endfunction

  function automatic logic [WIDTH-1:0] rnd_w();
    return WIDTH'({$urandom(), $urandom()});
  endfunction

  task automatic drive(input logic [WIDTH-1:0] k, input logic [WIDTH-1:0] m,
                       input logic [ADDR_W-1:0] e, input bit inv);
    upd_key   = k;
    upd_mask  = m;
    upd_entry = e;
`ifdef FRACTCAM_INVALIDATE_EN
    upd_inv   = inv;
`endif
  endtask

  task automatic run_rule(input logic [WIDTH-1:0] k, input logic [WIDTH-1:0] m,
                          input logic [ADDR_W-1:0] e, input bit inv, input string tag);
    @(negedge clk);
    chk({tag, ".ready_before"}, upd_ready, 1);
    upd_valid = 1'b1;
    drive(k, m, e, inv);
    @(posedge clk);
    @(negedge clk);
    upd_valid = 1'b0;
    drive(rnd_w(), ~m, ~e, !inv);
    for (int c = 0; c < NLUT; c++) begin
      chk({tag, ".wr_en"}, wr_en, 1);
      chk({tag, ".wr_row"}, wr_row, e);
      chk({tag, ".wr_lut_addr"}, wr_lut_addr, c);
      chk({tag, ".wr_data"}, wr_data, model(k, m, c, inv));
      chk({tag, ".stall"}, search_stall, 1);
      chk({tag, ".ready_busy"}, upd_ready, 0);
      chk({tag, ".done_early"}, upd_done, 0);
      @(negedge clk);
    end
    chk({tag, ".done"}, upd_done, 1);
    chk({tag, ".wr_en_done"}, wr_en, 0);
    chk({tag, ".stall_done"}, search_stall, 1);
    chk({tag, ".ready_done"}, upd_ready, 0);
    @(negedge clk);
    chk({tag, ".ready_after"}, upd_ready, 1);
    chk({tag, ".done_after"}, upd_done, 0);
    chk({tag, ".stall_after"}, search_stall, 0);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".ready"}, upd_ready, 1);
    chk({tag, ".wr_en"}, wr_en, 0);
    chk({tag, ".wr_row"}, wr_row, 0);
    chk({tag, ".wr_lut_addr"}, wr_lut_addr, 0);
    chk({tag, ".wr_data"}, wr_data, 0);
    chk({tag, ".stall"}, search_stall, 0);
    chk({tag, ".done"}, upd_done, 0);
  endtask

  initial begin
    logic [WIDTH-1:0]  ka, ma, kb, mb;
    logic [ADDR_W-1:0] ea, eb;
    int acc_k, stall_bad, seen, bad;

    reset     = 1'b0;
    upd_valid = 1'b0;
    drive('0, '0, '0, 1'b0);
    repeat (3) @(negedge clk);
    chk_quiet("reset");
    reset = 1'b1;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (wr_en !== 1'b0 || upd_done !== 1'b0 || upd_ready !== 1'b1) bad++;
    end
    chk("idle_quiet", bad, 0);

    run_rule(40'h00_0000_001F, '0, 6'd3, 1'b0, "exact");
    run_rule(40'h12_3456_789A, '1, 6'd17, 1'b0, "dontcare");
    repeat (3) begin
      ka = rnd_w();
      ma = rnd_w() & rnd_w();
      run_rule(ka, ma, ADDR_W'($urandom_range(0, DEPTH - 1)), 1'b0, "random");
    end

    // valid held high across two rules: second must wait a full sweep
    ka = rnd_w(); ma = rnd_w() & rnd_w(); ea = 6'd9;
    kb = rnd_w(); mb = rnd_w() & rnd_w(); eb = 6'd42;
    @(negedge clk);
    upd_valid = 1'b1;
    drive(ka, ma, ea, 1'b0);
    @(posedge clk);
    @(negedge clk);
    drive(kb, mb, eb, 1'b0);
    acc_k = -1;
    stall_bad = 0;
    for (int k = 1; k <= 40; k++) begin
      if (upd_ready === 1'b1) begin
        acc_k = k;
        break;
      end
      if (search_stall !== 1'b1) stall_bad++;
      @(negedge clk);
    end
    chk("busy.accept_gap", acc_k, NLUT + 2);
    chk("busy.stall_cover", stall_bad, 0);
    chk("busy.stall_idle", search_stall, 0);
    @(posedge clk);
    @(negedge clk);
    upd_valid = 1'b0;
    drive(rnd_w(), rnd_w(), '0, 1'b0);
    chk("busy.second_row", wr_row, eb);
    chk("busy.second_addr", wr_lut_addr, 0);
    chk("busy.second_data", wr_data, model(kb, mb, 0, 1'b0));
    seen = 0;
    for (int k = 0; k < 40 && seen == 0; k++) begin
      @(negedge clk);
      if (upd_done === 1'b1) seen = 1;
    end
    chk("busy.second_done", seen, 1);
    @(negedge clk);

    // async reset in the middle of a sweep
    upd_valid = 1'b1;
    drive(rnd_w(), '0, 6'd21, 1'b0);
    @(posedge clk);
    @(negedge clk);
    upd_valid = 1'b0;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      if (wr_en === 1'b1 && wr_lut_addr === 5'd10) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    chk("rst_mid.reached", seen, 1);
    reset = 1'b0;
    #1;
    chk_quiet("rst_mid");
    @(negedge clk);
    reset = 1'b1;
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (upd_done !== 1'b0 || wr_en !== 1'b0) bad++;
    end
    chk("rst_mid.no_done", bad, 0);

`ifdef FRACTCAM_INVALIDATE_EN
    run_rule(rnd_w(), rnd_w(), 6'd63, 1'b1, "invalidate");
`endif
    run_rule(40'hFF_FFFF_FFE0, 40'h00_0000_0C03, 6'd63, 1'b0, "last_entry");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
